// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data memory arbiter with RMW byte/half stores and load extension
// Optional DMEM_ARB_ROUND_ROBIN_EN: alternate winner on simultaneous requests (default: port 0 priority).
module dmem_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [2:0]            p0_funct3,
  input  logic [DM_ADDRESS-1:0] p0_addr,
  input  logic [DATA_W-1:0]     p0_wdata,
  output logic                  p0_gnt,
  output logic                  p0_done,
  output logic [DATA_W-1:0]     p0_rdata,
  output logic                  p0_err,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [2:0]            p1_funct3,
  input  logic [DM_ADDRESS-1:0] p1_addr,
  input  logic [DATA_W-1:0]     p1_wdata,
  output logic                  p1_gnt,
  output logic                  p1_done,
  output logic [DATA_W-1:0]     p1_rdata,
  output logic                  p1_err,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [3:0]            mem_wr,
  input  logic [DATA_W-1:0]     mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;

  state_t                state, state_nx;
  logic                  any_req;
  logic                  win_nx;
  logic                  win_q;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [DM_ADDRESS-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     merged_q;
  logic                  err_q;
  logic                  gnt0_q, gnt1_q;
  logic [DATA_W-1:0]     rdata0_q, rdata1_q;

  logic                  sel_we;
  logic [2:0]            sel_f3;
  logic [DM_ADDRESS-1:0] sel_addr;
  logic [DATA_W-1:0]     sel_wdata;
  logic                  sel_err;
  logic [DATA_W-1:0]     lane;
  logic [DATA_W-1:0]     load_ext;
  logic [DATA_W-1:0]     merged;

  assign any_req = p0_req | p1_req;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic last_q;

  // Reset points at port 1 so port 0 takes the first contested grant.
  always_ff @(posedge clk) begin
    if (!reset_n)
      last_q <= 1'b1;
    else if (state == IDLE && any_req)
      last_q <= win_nx;
  end

  assign win_nx = (p0_req && p1_req) ? ~last_q : p1_req;
`else
  assign win_nx = p1_req && !p0_req;
`endif

  function automatic logic access_err(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic bad;
    if (we)
      bad = f3[2] || (f3[1:0] == 2'b11);
    else
      bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    if (f3[1:0] == 2'b01 && a[0])
      bad = 1'b1;
    if (f3[1:0] == 2'b10 && a != 2'b00)
      bad = 1'b1;
    return bad;
  endfunction

  always_comb begin
    sel_we    = win_nx ? p1_we     : p0_we;
    sel_f3    = win_nx ? p1_funct3 : p0_funct3;
    sel_addr  = win_nx ? p1_addr   : p0_addr;
    sel_wdata = win_nx ? p1_wdata  : p0_wdata;
    sel_err   = access_err(sel_we, sel_f3, sel_addr[1:0]);
  end

  // Halves are always 2-aligned here, so the byte-lane shift also selects the half.
  always_comb begin
    lane = mem_rdata >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b100:  load_ext = {24'd0, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b101:  load_ext = {16'd0, lane[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    merged = mem_rdata;
    if (f3_q[1:0] == 2'b00)
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (any_req) begin
          if (sel_err)
            state_nx = DONE;
          else if (sel_we && sel_f3[1:0] == 2'b10)
            state_nx = WR;
          else
            state_nx = RD;
        end
      end
      RD:      state_nx = CAP;
      CAP:     state_nx = we_q ? WR : DONE;
      WR:      state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      win_q    <= 1'b0;
      we_q     <= 1'b0;
      f3_q     <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      err_q    <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state  <= state_nx;
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            win_q   <= win_nx;
            we_q    <= sel_we;
            f3_q    <= sel_f3;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            err_q   <= sel_err;
            gnt0_q  <= ~win_nx;
            gnt1_q  <= win_nx;
            if (sel_err && !win_nx) rdata0_q <= '0;
            if (sel_err &&  win_nx) rdata1_q <= '0;
          end
        end
        CAP: begin
          if (we_q)
            merged_q <= merged;
          else if (win_q)
            rdata1_q <= load_ext;
          else
            rdata0_q <= load_ext;
        end
        default: ;
      endcase
    end
  end

  assign p0_gnt    = gnt0_q;
  assign p1_gnt    = gnt1_q;
  assign p0_done   = (state == DONE) && !win_q;
  assign p1_done   = (state == DONE) &&  win_q;
  assign p0_err    = p0_done && err_q;
  assign p1_err    = p1_done && err_q;
  assign p0_rdata  = rdata0_q;
  assign p1_rdata  = rdata1_q;
  assign mem_addr  = {addr_q[DM_ADDRESS-1:2], 2'b00};
  assign mem_wdata = (f3_q[1:0] == 2'b10) ? wdata_q : merged_q;
  assign mem_wr    = (state == WR) ? 4'b1111 : 4'b0000;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [2:0]  p0_funct3, p1_funct3;
  logic [8:0]  p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic        p0_gnt, p0_done, p0_err, p1_gnt, p1_done, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_wr;

  logic [31:0] mem [0:127];
  logic        pre_en;
  logic [6:0]  pre_idx;
  logic [31:0] pre_data;

  int n_cmp = 0;
  int n_bad = 0;

  int          r_gnt, r_done, r_wrcnt, r_wrcyc;
  logic [31:0] r_wrdata, r_rdata;
  logic        r_err;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_funct3(p0_funct3), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_funct3(p1_funct3), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata)
  );

  // Memory model: registered read, full-word write.
  always @(posedge clk) begin
    if (pre_en)
      mem[pre_idx] <= pre_data;
    else if (mem_wr == 4'b1111)
      mem[mem_addr[8:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[8:2]];
  end

  task automatic preload(input logic [6:0] idx, input logic [31:0] data);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = idx; pre_data = data;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Cycle c = period after the c-th edge, counting the capture edge as the first.
  task automatic access(input int port, input logic we, input logic [2:0] f3,
                        input logic [8:0] addr, input logic [31:0] wd);
    logic g, d;
    @(negedge clk);
    r_gnt = -1; r_done = -1; r_wrcnt = 0; r_wrcyc = -1; r_wrdata = 0; r_rdata = 0; r_err = 0;
    if (port == 0) begin
      p0_req = 1'b1; p0_we = we; p0_funct3 = f3; p0_addr = addr; p0_wdata = wd;
    end else begin
      p1_req = 1'b1; p1_we = we; p1_funct3 = f3; p1_addr = addr; p1_wdata = wd;
    end
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      g = (port == 0) ? p0_gnt : p1_gnt;
      d = (port == 0) ? p0_done : p1_done;
      if (g) begin
        if (r_gnt < 0) r_gnt = c;
        p0_req = 1'b0; p1_req = 1'b0;
      end
      if (mem_wr == 4'b1111) begin
        r_wrcnt++; r_wrcyc = c; r_wrdata = mem_wdata;
      end
      if (d) begin
        r_done  = c;
        r_rdata = (port == 0) ? p0_rdata : p1_rdata;
        r_err   = (port == 0) ? p0_err : p1_err;
        break;
      end
    end
    p0_req = 1'b0; p1_req = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({p0_gnt, p1_gnt, p0_done, p1_done, p0_err, p1_err} !== 6'b0) begin n_bad++; $display("FAIL reset_flags got %b want 000000", {p0_gnt, p1_gnt, p0_done, p1_done, p0_err, p1_err}); end
    n_cmp++; if ({p0_rdata, p1_rdata} !== 64'd0) begin n_bad++; $display("FAIL reset_rdata got %h/%h want 0/0", p0_rdata, p1_rdata); end
    n_cmp++; if ({mem_wr, mem_addr} !== 13'd0) begin n_bad++; $display("FAIL reset_mem got wr=%b addr=%h want 0", mem_wr, mem_addr); end
    reset_n = 1'b1;
  endtask

  task automatic test_lb;
    preload(7'h04, 32'h8899AABB);
    access(0, 1'b0, 3'b000, 9'h012, 32'h0);
    n_cmp++; if (r_gnt !== 1) begin n_bad++; $display("FAIL lb_gnt_cycle got %0d want 1", r_gnt); end
    n_cmp++; if (r_done !== 3) begin n_bad++; $display("FAIL lb_done_cycle got %0d want 3", r_done); end
    n_cmp++; if (r_rdata !== 32'hFFFFFF99) begin n_bad++; $display("FAIL lb_rdata got %h want ffffff99", r_rdata); end
    n_cmp++; if (r_err !== 1'b0) begin n_bad++; $display("FAIL lb_err got %b want 0", r_err); end
  endtask

  task automatic test_load_lanes;
    access(0, 1'b0, 3'b101, 9'h012, 32'h0);
    n_cmp++; if (r_rdata !== 32'h00008899) begin n_bad++; $display("FAIL lhu_rdata got %h want 00008899", r_rdata); end
    access(0, 1'b0, 3'b010, 9'h010, 32'h0);
    n_cmp++; if (r_rdata !== 32'h8899AABB) begin n_bad++; $display("FAIL lw_rdata got %h want 8899aabb", r_rdata); end
    access(0, 1'b0, 3'b001, 9'h010, 32'h0);
    n_cmp++; if (r_rdata !== 32'hFFFFAABB) begin n_bad++; $display("FAIL lh_rdata got %h want ffffaabb", r_rdata); end
    access(1, 1'b0, 3'b100, 9'h013, 32'h0);
    n_cmp++; if (r_rdata !== 32'h00000088) begin n_bad++; $display("FAIL lbu_p1_rdata got %h want 00000088", r_rdata); end
  endtask

  task automatic test_stores;
    preload(7'h08, 32'h11223344);
    access(1, 1'b1, 3'b000, 9'h021, 32'h000000EE);
    n_cmp++; if (r_wrcnt !== 1) begin n_bad++; $display("FAIL sb_wr_count got %0d want 1", r_wrcnt); end
    n_cmp++; if (r_wrcyc !== 3) begin n_bad++; $display("FAIL sb_wr_cycle got %0d want 3", r_wrcyc); end
    n_cmp++; if (r_wrdata !== 32'h1122EE44) begin n_bad++; $display("FAIL sb_wdata got %h want 1122ee44", r_wrdata); end
    n_cmp++; if (r_done !== 4) begin n_bad++; $display("FAIL sb_done_cycle got %0d want 4", r_done); end
    access(1, 1'b0, 3'b010, 9'h020, 32'h0);
    n_cmp++; if (r_rdata !== 32'h1122EE44) begin n_bad++; $display("FAIL sb_readback got %h want 1122ee44", r_rdata); end
    access(0, 1'b1, 3'b010, 9'h030, 32'hCAFEF00D);
    n_cmp++; if (r_done !== 2 || r_wrcyc !== 1) begin n_bad++; $display("FAIL sw_timing got done=%0d wr=%0d want 2/1", r_done, r_wrcyc); end
    access(0, 1'b1, 3'b001, 9'h032, 32'h55551234);
    n_cmp++; if (r_wrdata !== 32'h1234F00D || r_done !== 4) begin n_bad++; $display("FAIL sh_merge got %h done=%0d want 1234f00d/4", r_wrdata, r_done); end
    access(0, 1'b0, 3'b010, 9'h030, 32'h0);
    n_cmp++; if (r_rdata !== 32'h1234F00D) begin n_bad++; $display("FAIL sh_readback got %h want 1234f00d", r_rdata); end
  endtask

  task automatic test_errors;
    logic [2:0]  f3s  [4] = '{3'b001, 3'b010, 3'b011, 3'b100};
    logic        wes  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [8:0]  adrs [4] = '{9'h013, 9'h006, 9'h000, 9'h000};
    for (int i = 0; i < 4; i++) begin
      access(0, wes[i], f3s[i], adrs[i], 32'hFFFFFFFF);
      n_cmp++; if (r_gnt !== 1 || r_done !== 1) begin n_bad++; $display("FAIL err%0d_timing got gnt=%0d done=%0d want 1/1", i, r_gnt, r_done); end
      n_cmp++; if (r_err !== 1'b1 || r_rdata !== 32'h0) begin n_bad++; $display("FAIL err%0d_flag got err=%b rdata=%h want 1/0", i, r_err, r_rdata); end
      n_cmp++; if (r_wrcnt !== 0) begin n_bad++; $display("FAIL err%0d_nowrite got %0d want 0", i, r_wrcnt); end
    end
  endtask

  task automatic test_arbitration;
    int g0, g1, d0, d1, n;
    int gp [3];
    int gc [3];
    logic [31:0] rd1;
    preload(7'h00, 32'hA5A50001);
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    g0 = -1; g1 = -1; d0 = -1; d1 = -1; rd1 = 0;
    p0_req = 1'b1; p0_we = 1'b0; p0_funct3 = 3'b010; p0_addr = 9'h000;
    p1_req = 1'b1; p1_we = 1'b0; p1_funct3 = 3'b010; p1_addr = 9'h000;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (p0_gnt && g0 < 0) begin g0 = c; p0_req = 1'b0; end
      if (p1_gnt && g1 < 0) begin g1 = c; p1_req = 1'b0; end
      if (p0_done) d0 = c;
      if (p1_done) begin d1 = c; rd1 = p1_rdata; end
      if (d0 >= 0 && d1 >= 0) break;
    end
    p0_req = 1'b0; p1_req = 1'b0;
    n_cmp++; if (g0 !== 1 || d0 !== 3) begin n_bad++; $display("FAIL arb_p0_first got gnt=%0d done=%0d want 1/3", g0, d0); end
    n_cmp++; if (g1 !== 5 || d1 !== 7) begin n_bad++; $display("FAIL arb_p1_waits got gnt=%0d done=%0d want 5/7", g1, d1); end
    n_cmp++; if (rd1 !== 32'hA5A50001) begin n_bad++; $display("FAIL arb_p1_rdata got %h want a5a50001", rd1); end

    // Both keep requesting; port 1 won last above.
    @(negedge clk);
    n = 0;
    p0_req = 1'b1; p1_req = 1'b1;
    for (int c = 1; c <= 30 && n < 3; c++) begin
      @(negedge clk);
      if (p0_gnt) begin gp[n] = 0; gc[n] = c; n++; end
      else if (p1_gnt) begin gp[n] = 1; gc[n] = c; n++; end
    end
    p0_req = 1'b0; p1_req = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL arb_cont_count got %0d want 3", n); end
    else begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      n_cmp++; if (gp[0] !== 0 || gp[1] !== 1 || gp[2] !== 0) begin n_bad++; $display("FAIL arb_rr_order got %0d%0d%0d want 010", gp[0], gp[1], gp[2]); end
`else
      n_cmp++; if (gp[0] !== 0 || gp[1] !== 0 || gp[2] !== 0) begin n_bad++; $display("FAIL arb_fixed_order got %0d%0d%0d want 000", gp[0], gp[1], gp[2]); end
`endif
      n_cmp++; if (gc[0] !== 1 || gc[1] !== 5 || gc[2] !== 9) begin n_bad++; $display("FAIL arb_cont_spacing got %0d/%0d/%0d want 1/5/9", gc[0], gc[1], gc[2]); end
    end
  endtask

  task automatic test_reset_mid_op;
    int wr_seen;
    preload(7'h10, 32'h55667788);
    @(negedge clk);
    p0_req = 1'b1; p0_we = 1'b1; p0_funct3 = 3'b000; p0_addr = 9'h041; p0_wdata = 32'h000000AA;
    @(negedge clk);
    n_cmp++; if (p0_gnt !== 1'b1) begin n_bad++; $display("FAIL rst_mid_gnt got %b want 1", p0_gnt); end
    p0_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    n_cmp++; if ({p0_gnt, p0_done, p0_err, mem_wr, mem_addr} !== 16'd0 || p0_rdata !== 32'd0) begin n_bad++; $display("FAIL rst_mid_outputs got gnt=%b done=%b err=%b wr=%b addr=%h rdata=%h want 0", p0_gnt, p0_done, p0_err, mem_wr, mem_addr, p0_rdata); end
    reset_n = 1'b1;
    wr_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (mem_wr !== 4'b0000) wr_seen++;
    end
    n_cmp++; if (wr_seen !== 0) begin n_bad++; $display("FAIL rst_mid_nowrite got %0d want 0", wr_seen); end
    n_cmp++; if (mem[16] !== 32'h55667788) begin n_bad++; $display("FAIL rst_mid_mem got %h want 55667788", mem[16]); end
    access(0, 1'b0, 3'b010, 9'h040, 32'h0);
    n_cmp++; if (r_gnt !== 1 || r_done !== 3 || r_rdata !== 32'h55667788) begin n_bad++; $display("FAIL rst_mid_idle got gnt=%0d done=%0d rdata=%h want 1/3/55667788", r_gnt, r_done, r_rdata); end
  endtask

  initial begin
    reset_n = 1'b0; pre_en = 1'b0; pre_idx = '0; pre_data = '0;
    p0_req = 1'b0; p0_we = 1'b0; p0_funct3 = '0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_funct3 = '0; p1_addr = '0; p1_wdata = '0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    test_reset;
    test_lb;
    test_load_lanes;
    test_stores;
    test_errors;
    test_arbitration;
    test_reset_mid_op;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
